// File: rtl/axi4_lite_if.sv
// rtl/axi4_lite_if.sv - AXI4-Lite 32-bit register access bus with master/slave views
interface axi4_lite_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_csr_bank.sv
// rtl/axi4_lite_csr_bank.sv - parametrised AXI4-Lite control/status register bank
module axi4_lite_csr_bank #(
  parameter logic [31:0]               BASE_ADDR     = 32'h0000_0000,
  parameter int                        CR_CNT        = 4,
  parameter int                        SR_CNT        = 2,
  parameter logic [CR_CNT-1:0][31:0]   CR_RST_VAL    = '0,
  parameter logic [CR_CNT-1:0]         CR_PULSE_MASK = '0,
  localparam int                       SR_W          = (SR_CNT > 0) ? SR_CNT : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  axi4_lite_if.slave               csr_i,
  output logic [CR_CNT-1:0][31:0]  cr_o,
  output logic [CR_CNT-1:0]        cr_wr_stb_o,
  input  logic [SR_W-1:0][31:0]    sr_i,
  output logic [SR_W-1:0]          sr_rd_stb_o
);

  typedef enum logic [1:0] {CLS_CR, CLS_SR, CLS_OOR} cls_t;

  // Addresses below BASE_ADDR wrap to a huge index and fall out of range.
  function automatic logic [31:0] word_idx(input logic [31:0] addr);
    return (addr - BASE_ADDR) >> 2;
  endfunction

  function automatic cls_t classify(input logic [31:0] idx);
    if (idx < 32'(CR_CNT))               return CLS_CR;
    else if (idx < 32'(CR_CNT + SR_CNT)) return CLS_SR;
    else                                 return CLS_OOR;
  endfunction

  logic                     aw_full, w_full;
  logic [31:0]              aw_addr_q, w_data_q;
  logic [3:0]               w_strb_q;
  logic                     bvalid_q, rvalid_q;
  logic [1:0]               bresp_q, rresp_q;
  logic [31:0]              rdata_q;
  logic [CR_CNT-1:0][31:0]  cr_q;
  logic [CR_CNT-1:0]        cr_stb_q;
  logic [SR_W-1:0]          sr_stb_q;

  logic        aw_hs, w_hs, ar_hs, commit;
  logic [31:0] wr_idx, ar_idx, rd_data_n;
  cls_t        wr_cls, ar_cls;
  logic [1:0]  wr_resp_n, rd_resp_n;

  assign aw_hs  = csr_i.awvalid && !aw_full;
  assign w_hs   = csr_i.wvalid && !w_full;
  assign ar_hs  = csr_i.arvalid && !rvalid_q;
  assign commit = aw_full && w_full && (!bvalid_q || csr_i.bready);

  assign wr_idx = word_idx(aw_addr_q);
  assign wr_cls = classify(wr_idx);
  assign ar_idx = word_idx(csr_i.araddr);
  assign ar_cls = classify(ar_idx);

  assign csr_i.awready = !aw_full;
  assign csr_i.wready  = !w_full;
  assign csr_i.bvalid  = bvalid_q;
  assign csr_i.bresp   = bresp_q;
  assign csr_i.arready = !rvalid_q;
  assign csr_i.rvalid  = rvalid_q;
  assign csr_i.rdata   = rdata_q;
  assign csr_i.rresp   = rresp_q;
  assign cr_o          = cr_q;
  assign cr_wr_stb_o   = cr_stb_q;
  assign sr_rd_stb_o   = sr_stb_q;

  // Write response code for the buffered address.
  always_comb begin
    wr_resp_n = 2'b00;
    case (wr_cls)
      CLS_CR:  wr_resp_n = 2'b00;
      CLS_SR:  wr_resp_n = 2'b10;
      default: wr_resp_n = 2'b11;
    endcase
  end

  // Read data mux; pulse registers always read back as zero.
  always_comb begin
    rd_data_n = '0;
    rd_resp_n = 2'b00;
    case (ar_cls)
      CLS_CR: begin
        for (int i = 0; i < CR_CNT; i++) begin
          if (ar_idx == 32'(i) && !CR_PULSE_MASK[i]) rd_data_n = cr_q[i];
        end
      end
      CLS_SR: begin
        for (int j = 0; j < SR_CNT; j++) begin
          if (ar_idx == 32'(CR_CNT + j)) rd_data_n = sr_i[j];
        end
      end
      default: rd_resp_n = 2'b11;
    endcase
  end

  // One-entry AW and W buffers, filled independently and drained together on commit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_full   <= 1'b0;
      aw_addr_q <= '0;
      w_full    <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (aw_hs) begin
        aw_full   <= 1'b1;
        aw_addr_q <= csr_i.awaddr;
      end else if (commit) begin
        aw_full <= 1'b0;
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= csr_i.wdata;
        w_strb_q <= csr_i.wstrb;
      end else if (commit) begin
        w_full <= 1'b0;
      end
    end
  end

  // B channel: a commit (re)loads the response even on the edge the previous one is taken.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= wr_resp_n;
    end else if (bvalid_q && csr_i.bready) begin
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
    end
  end

  // Control registers: byte-strobed update on commit; pulse registers fall back to 0 each cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < CR_CNT; i++) begin
        cr_q[i] <= CR_PULSE_MASK[i] ? 32'h0 : CR_RST_VAL[i];
      end
      cr_stb_q <= '0;
    end else begin
      cr_stb_q <= '0;
      for (int i = 0; i < CR_CNT; i++) begin
        if (CR_PULSE_MASK[i]) cr_q[i] <= '0;
        if (commit && wr_cls == CLS_CR && wr_idx == 32'(i)) begin
          cr_stb_q[i] <= 1'b1;
          for (int k = 0; k < 4; k++) begin
            if (w_strb_q[k]) cr_q[i][8*k +: 8] <= w_data_q[8*k +: 8];
          end
        end
      end
    end
  end

  // R channel: sample on AR handshake, hold until R handshake, then return to zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data_n;
      rresp_q  <= rd_resp_n;
    end else if (rvalid_q && csr_i.rready) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
    end
  end

  // Status read strobe, aligned with the cycle rvalid rises.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_stb_q <= '0;
    end else begin
      for (int j = 0; j < SR_W; j++) begin
        sr_stb_q[j] <= ar_hs && ar_cls == CLS_SR && ar_idx == 32'(CR_CNT + j);
      end
    end
  end

endmodule

// File: doc/axi4_lite_csr_bank.md
# axi4_lite_csr_bank

Generic, parametrised AXI4-Lite register bank: the next generation of the per-block CSR files used across the image-processing pipeline (white balance, etc.). It provides a configurable number of read/write control registers with per-register reset values, self-clearing pulse registers, read-only status registers with read strobes, byte strobes, and full SLVERR/DECERR responses. Every accepted AXI transaction receives a response. Processing blocks wrap it, mapping `cr_o`/`sr_i` onto their own control interfaces.

## Interface
- `BASE_ADDR`, 32'h0000_0000: byte address of register 0; must be 4-byte aligned.
- `CR_CNT`, 4: number of control registers (≥1), word indices 0..CR_CNT-1.
- `SR_CNT`, 2: number of status registers (≥0), word indices CR_CNT..CR_CNT+SR_CNT-1.
- `CR_RST_VAL`, all 0: `logic [CR_CNT-1:0][31:0]`, reset value per control register.
- `CR_PULSE_MASK`, 0: `logic [CR_CNT-1:0]`; bit set means the register is a self-clearing pulse register.
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `csr_i`  axi4_lite_if.slave  32-bit addr/data  register access port.
- `cr_o`  out  CR_CNT×32  control register contents.
- `cr_wr_stb_o`  out  CR_CNT  one-cycle pulse per committed write to CR i (any strobe).
- `sr_i`  in  SR_CNT×32  status values, sampled at AR handshake.
- `sr_rd_stb_o`  out  max(SR_CNT,1)  one-cycle pulse per accepted read of SR j (for clear-on-read in the owner).

## Operation
- Index decode: `idx = (addr - BASE_ADDR) >> 2`, unsigned 32-bit; addr[1:0] ignored. Addresses below BASE_ADDR wrap to a huge idx and therefore decode as out of range.
- Classes: CR (idx < CR_CNT), SR (CR_CNT ≤ idx < CR_CNT+SR_CNT), OOR (everything else).
- Write channel: AW and W are accepted independently into one-entry buffers (`aw_full`, `w_full`). `awready = !aw_full`, `wready = !w_full`. Either order or the same cycle is legal.
- Commit: occurs on the edge where `aw_full && w_full && (!bvalid || bready)`. Both buffers clear. `bvalid` is then set with:
  - CR, normal register: bytes with `wstrb[k]` set are updated; `bresp` = 2'b00; `cr_wr_stb_o[i]` pulses.
  - CR, pulse register: `cr_o[i]` takes the strobed bytes (other bytes 0) for exactly one cycle, then returns to 0; `bresp` = 00; strobe pulses.
  - SR: no state change; `bresp` = 2'b10 (SLVERR).
  - OOR: no state change; `bresp` = 2'b11 (DECERR).
- Write with `wstrb` = 0 to a CR: no data change, `bresp` = 00, strobe still pulses.
- Read channel: `arready = !rvalid`. On AR handshake, the register is sampled (the value before any same-edge commit). `rvalid` rises next cycle and holds with stable `rdata`/`rresp` until `rready`.
  - CR normal: register value, `rresp` 00.
  - CR pulse: returns 0, `rresp` 00.
  - SR: `sr_i[j]`, `rresp` 00; `sr_rd_stb_o[j]` pulses in the cycle `rvalid` rises.
  - OOR: returns 0, `rresp` 11.
- After the R handshake, `rdata` returns to 0 and `rresp` to 00. After the B handshake, `bresp` returns to 00.
- Reads and writes are fully independent and may proceed concurrently.

## Timing
- Reset values:
  - `awready`/`wready`/`arready` = 1.
  - `bvalid`/`rvalid` = 0; `bresp`/`rresp` = 0; `rdata` = 0.
  - `cr_o[i]` = `CR_RST_VAL[i]`, or 0 if pulse.
  - All strobes = 0.
- Reset asserted mid-transaction: buffered AW/W and pending B/R responses are dropped, with no response issued. All registers return to their reset values.
- Write latency: AW and W handshake at edge E0. Buffers are full after E0, so commit happens at E1 if no B is pending. After E1, `bvalid`, the new `cr_o` and `cr_wr_stb_o` are all visible, and `awready`/`wready` are 1 again.
- Back-to-back writes with `bready` held high: one commit every 2 cycles.
- With `bvalid` held (bready = 0): the next AW/W may be buffered, but its commit stalls until the B handshake. Commit and B handshake may occur on the same edge.
- Read latency: AR handshake at E0, `rvalid` after E0. The next AR is accepted on the edge after the R handshake completes.
- Pulse register: `cr_o[i]` is non-zero for exactly one cycle, the same cycle as `cr_wr_stb_o[i]`.

## Test plan
- Reset with CR_RST_VAL[0]=32'h2: `cr_o[0]`=2, and reading 0x0 returns 2 with `rresp` 00; all ready signals = 1, all valid signals = 0.
- Byte strobes: write 0xAABBCCDD with `wstrb`=4'b0101 to CR1 (value 0) → `cr_o[1]`=0x00BB00DD, `cr_wr_stb_o[1]` high for one cycle, `bresp` 00, read-back 0x00BB00DD.
- W issued 3 cycles before AW, with `bready` held low for 4 cycles → a single commit; a second AW/W is buffered but not committed until the first B handshake; two B responses in order.
- Pulse CR2 (mask bit 2): write 0x1 → `cr_o[2]`=1 for exactly 1 cycle, then 0; read of CR2 returns 0.
- SR0 with `sr_i[0]`=0x1234: read → 0x1234, `rresp` 00, `sr_rd_stb_o[0]` 1 cycle; a write to SR0 → SLVERR with `cr_o` unchanged.
- Read/write at BASE_ADDR−4 and at (CR_CNT+SR_CNT)·4 → DECERR, `rdata`=0, no state change; assert reset mid-write → no B response and `cr_o` returns to `CR_RST_VAL`.
